instr_fetch_unit: RTL

//   Fetch stage feeding control_unit/datapath: holds PC, issues one request at a time to instruction

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time and hands the
// returned word downstream over a valid/ready handshake, picking the next PC on each consume.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_fault
);

    // state   | meaning
    // S_REQ   | request driven at pc, waiting for grant
    // S_WAIT  | granted, waiting for the response word
    // S_HOLD  | instruction presented, waiting for consume
    // S_DRAIN | flushed with a request in flight; drop its response
    // S_FAULT | next PC misaligned; idle until flush
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_code_q, instr_code_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] next_pc;

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_code     = instr_code_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + 32'd4;
    assign fetch_fault    = fault_q;

    always_comb begin
        case (pc_src)
            2'b00:   next_pc = pc_q + 32'd4;
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jal_target;
            default: next_pc = {jalr_target[31:1], 1'b0};
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_code_d  = instr_code_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_code_d  = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_code_d  = NOP_INSTR;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: state_d = S_REQ;
        endcase

        // Flush overrides everything; a request still in flight must have its response drained.
        if (flush) begin
            pc_d          = flush_pc;
            instr_valid_d = 1'b0;
            instr_code_d  = NOP_INSTR;
            fault_d       = (flush_pc[1:0] != 2'b00);
            if (flush_pc[1:0] != 2'b00)
                state_d = S_FAULT;
            else if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid)
                state_d = S_DRAIN;
            else if (state_q == S_REQ && imem_gnt)
                state_d = S_DRAIN;
            else
                state_d = S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_code_q  <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_code_q  <= instr_code_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule
